// File: rtl/lsu_bytelane_if.sv
// Memory-side bus between lsu_bytelane and the data memory.
// The master drives the request, the address, the write data and the byte enables.
interface lsu_bytelane_if #(
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [31:0]       busaddr;
  logic              rd_req;
  logic              wr_req;
  logic              rw_wait;
  logic [DATA_W-1:0] wr_data;
  logic [BE_W-1:0]   wr_be;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output busaddr, rd_req, wr_req, wr_data, wr_be,
    input  rw_wait, rd_data
  );

  modport slave (
    input  busaddr, rd_req, wr_req, wr_data, wr_be,
    output rw_wait, rd_data
  );
endinterface

// File: rtl/lsu_bytelane.sv
// Load/store stage with byte-lane write enables, load realignment and sign extension.
// It also handles multi-register transfers, base writeback and alignment faults.
module lsu_bytelane #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              inbubble,
  input  logic [31:0]       pc,
  input  logic              op_load,
  input  logic              op_multi,
  input  logic [1:0]        op_size,
  input  logic              op_signed,
  input  logic              op_up,
  input  logic              op_pre,
  input  logic              op_wb,
  input  logic [3:0]        op_rd,
  input  logic [3:0]        op_rn,
  input  logic [31:0]       op_base,
  input  logic [31:0]       op_offset,
  input  logic [31:0]       op_store,
  input  logic [15:0]       op_regs,
  output logic [3:0]        st_read,
  input  logic [31:0]       st_data,
  lsu_bytelane_if.master    bus,
  output logic              outstall,
  output logic              outbubble,
  output logic              out_write_reg,
  output logic [3:0]        out_write_num,
  output logic [31:0]       out_write_data,
  output logic              out_fault
);
  localparam int BE_W   = DATA_W / 8;
  localparam int LANE_W = $clog2(BE_W);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WB, S_DONE} state_t;

  state_t      r_state;
  logic        r_flush_pend, r_load, r_multi, r_signed, r_up, r_wbflag;
  logic [1:0]  r_size;
  logic [3:0]  r_rd, r_rn;
  logic [31:0] r_pc, r_addr, r_store, r_wbval;
  logic [15:0] r_regs;
  logic        r_wr_reg, r_fault, r_outbubble;
  logic [3:0]  r_wr_num;
  logic [31:0] r_wr_data;

  logic              w_accept, w_misalign;
  logic [4:0]        w_pop;
  logic [31:0]       w_ea, w_span, w_addr0, w_wbval, w_store, w_rdsh, w_ld;
  logic [3:0]        w_cur;
  logic [15:0]       w_regs_left;
  logic [LANE_W-1:0] w_lane;
  logic [BE_W-1:0]   w_be0;
  logic [DATA_W-1:0] w_wr_data;

  always_comb begin
    w_accept = (r_state == S_IDLE) && !inbubble && !flush && !r_flush_pend;
    w_ea     = op_up ? op_base + op_offset : op_base - op_offset;
    w_pop    = '0;
    for (int unsigned i = 0; i < 16; i++) w_pop = w_pop + 5'(op_regs[i]);
    w_span   = {25'd0, w_pop, 2'b00};
    if (op_multi) begin
      w_addr0    = op_pre ? (op_up ? op_base + 32'd4 : op_base - 32'd4) : op_base;
      w_wbval    = op_up ? op_base + w_span : op_base - w_span;
      w_misalign = (op_base[1:0] != 2'b00) || (op_regs == '0);
    end else begin
      w_addr0 = op_pre ? w_ea : op_base;
      w_wbval = w_ea;
      case (op_size)
        2'd0:    w_misalign = 1'b0;
        2'd1:    w_misalign = w_addr0[0];
        default: w_misalign = (w_addr0[1:0] != 2'b00);
      endcase
    end
  end

  // Ascending order takes the lowest remaining register, descending order the highest.
  always_comb begin
    w_cur = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (r_up) begin
        if (r_regs[15-i]) w_cur = 4'(15 - i);
      end else if (r_regs[i]) begin
        w_cur = 4'(i);
      end
    end
    w_regs_left = r_regs & ~(16'd1 << w_cur);
  end

  always_comb begin
    w_lane  = r_addr[LANE_W-1:0];
    w_store = r_multi ? ((w_cur == 4'd15) ? r_pc + 32'd12 : st_data) : r_store;
    case (r_size)
      2'd0:    w_be0 = BE_W'(4'h1);
      2'd1:    w_be0 = BE_W'(4'h3);
      default: w_be0 = BE_W'(4'hF);
    endcase
    w_wr_data = '0;
    for (int unsigned b = 0; b < BE_W; b++) begin
      case (r_size)
        2'd0:    w_wr_data[b*8 +: 8] = w_store[7:0];
        2'd1:    w_wr_data[b*8 +: 8] = w_store[(b % 2)*8 +: 8];
        default: w_wr_data[b*8 +: 8] = w_store[(b % 4)*8 +: 8];
      endcase
    end
    w_rdsh = 32'(bus.rd_data >> {w_lane, 3'b000});
    case (r_size)
      2'd0:    w_ld = {{24{r_signed & w_rdsh[7]}}, w_rdsh[7:0]};
      2'd1:    w_ld = {{16{r_signed & w_rdsh[15]}}, w_rdsh[15:0]};
      default: w_ld = w_rdsh;
    endcase
  end

  assign bus.busaddr = {r_addr[31:LANE_W], {LANE_W{1'b0}}};
  assign bus.rd_req  = (r_state == S_ACCESS) && r_load;
  assign bus.wr_req  = (r_state == S_ACCESS) && !r_load;
  assign bus.wr_data = w_wr_data;
  assign bus.wr_be   = w_be0 << w_lane;
  assign st_read     = w_cur;
  assign outstall    = w_accept || (r_state == S_ACCESS) || (r_state == S_WB);
  assign outbubble      = r_outbubble;
  assign out_write_reg  = r_wr_reg;
  assign out_write_num  = r_wr_num;
  assign out_write_data = r_wr_data;
  assign out_fault      = r_fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_flush_pend <= 1'b0;
      r_wr_reg     <= 1'b0;
      r_wr_num     <= '0;
      r_wr_data    <= '0;
      r_fault      <= 1'b0;
      r_outbubble  <= 1'b1;
    end else begin
      r_wr_reg    <= 1'b0;
      r_fault     <= 1'b0;
      r_outbubble <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (r_flush_pend) r_flush_pend <= 1'b0;
          if (w_accept) begin
            r_load   <= op_load;
            r_multi  <= op_multi;
            r_size   <= op_multi ? 2'd2 : op_size;
            r_signed <= op_signed;
            r_up     <= op_up;
            r_wbflag <= op_wb || !op_pre;
            r_rd     <= op_rd;
            r_rn     <= op_rn;
            r_pc     <= pc;
            r_addr   <= w_addr0;
            r_store  <= op_store;
            r_regs   <= op_regs;
            r_wbval  <= w_wbval;
            if (w_misalign) begin
              r_state     <= S_DONE;
              r_fault     <= 1'b1;
              r_outbubble <= 1'b0;
            end else begin
              r_state <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (flush) r_flush_pend <= 1'b1;
          if (!bus.rw_wait) begin
            if (r_load) begin
              r_wr_reg    <= 1'b1;
              r_wr_num    <= r_multi ? w_cur : r_rd;
              r_wr_data   <= w_ld;
              r_outbubble <= 1'b0;
            end
            r_addr <= r_up ? r_addr + 32'd4 : r_addr - 32'd4;
            r_regs <= w_regs_left;
            if (!r_multi || (w_regs_left == '0)) begin
              if (r_wbflag) begin
                r_state <= S_WB;
              end else begin
                r_state     <= S_DONE;
                r_outbubble <= 1'b0;
              end
            end
          end
        end
        S_WB: begin
          if (flush) r_flush_pend <= 1'b1;
          r_wr_reg    <= 1'b1;
          r_wr_num    <= r_rn;
          r_wr_data   <= r_wbval;
          r_outbubble <= 1'b0;
          r_state     <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_bytelane.sv
// Directed bench for lsu_bytelane: a 32-bit instance checked throughout, plus a 64-bit instance for lane checks.
// Expected register writes are queued when an operation is presented and popped as writebacks appear.
module tb_lsu_bytelane;
  logic        clk = 1'b0;
  logic        rst, flush, inbubble;
  logic [31:0] pc;
  logic        op_load, op_multi, op_signed, op_up, op_pre, op_wb;
  logic [1:0]  op_size;
  logic [3:0]  op_rd, op_rn;
  logic [31:0] op_base, op_offset, op_store;
  logic [15:0] op_regs;

  logic [3:0]  st_read32, st_read64;
  logic [31:0] st_data32, st_data64;
  logic        outstall, outbubble, out_write_reg, out_fault;
  logic [3:0]  out_write_num;
  logic [31:0] out_write_data;
  logic        outstall64, outbubble64, out_write_reg64, out_fault64;
  logic [3:0]  out_write_num64;
  logic [31:0] out_write_data64;

  int checks = 0;
  int failures = 0;

  typedef struct packed { logic [3:0] num; logic [31:0] data; } wb_t;
  wb_t sb_q[$];

  lsu_bytelane_if #(.DATA_W(32)) bus32 ();
  lsu_bytelane_if #(.DATA_W(64)) bus64 ();

  assign st_data32 = 32'hA000_0000 | {28'd0, st_read32};
  assign st_data64 = 32'hA000_0000 | {28'd0, st_read64};

  always #5 clk = ~clk;

  lsu_bytelane #(.DATA_W(32)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .inbubble(inbubble), .pc(pc),
    .op_load(op_load), .op_multi(op_multi), .op_size(op_size), .op_signed(op_signed),
    .op_up(op_up), .op_pre(op_pre), .op_wb(op_wb), .op_rd(op_rd), .op_rn(op_rn),
    .op_base(op_base), .op_offset(op_offset), .op_store(op_store), .op_regs(op_regs),
    .st_read(st_read32), .st_data(st_data32), .bus(bus32.master),
    .outstall(outstall), .outbubble(outbubble), .out_write_reg(out_write_reg),
    .out_write_num(out_write_num), .out_write_data(out_write_data), .out_fault(out_fault)
  );

  lsu_bytelane #(.DATA_W(64)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush), .inbubble(inbubble), .pc(pc),
    .op_load(op_load), .op_multi(op_multi), .op_size(op_size), .op_signed(op_signed),
    .op_up(op_up), .op_pre(op_pre), .op_wb(op_wb), .op_rd(op_rd), .op_rn(op_rn),
    .op_base(op_base), .op_offset(op_offset), .op_store(op_store), .op_regs(op_regs),
    .st_read(st_read64), .st_data(st_data64), .bus(bus64.master),
    .outstall(outstall64), .outbubble(outbubble64), .out_write_reg(out_write_reg64),
    .out_write_num(out_write_num64), .out_write_data(out_write_data64), .out_fault(out_fault64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wait(input logic w);
    bus32.rw_wait = w;
    bus64.rw_wait = w;
  endtask

  task automatic set_rd(input logic [31:0] v);
    bus32.rd_data = v;
    bus64.rd_data = {v, v};
  endtask

  task automatic present(input logic ld, input logic multi, input logic [1:0] sz,
                         input logic sgn, input logic up, input logic pre, input logic wb,
                         input logic [3:0] rd, input logic [3:0] rn,
                         input logic [31:0] base, input logic [31:0] off,
                         input logic [31:0] stv, input logic [15:0] regs);
    inbubble  = 1'b0;
    op_load   = ld;   op_multi  = multi; op_size = sz;  op_signed = sgn;
    op_up     = up;   op_pre    = pre;   op_wb   = wb;  op_rd     = rd;
    op_rn     = rn;   op_base   = base;  op_offset = off;
    op_store  = stv;  op_regs   = regs;
  endtask

  task automatic sb_push(input logic [3:0] n, input logic [31:0] d);
    wb_t e;
    e.num  = n;
    e.data = d;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && out_write_reg) begin
      checks++;
      assert (sb_q.size() != 0) else begin
        failures++;
        $error("FAIL sb_unexpected_write observed=num %0h data %0h expected=no write", out_write_num, out_write_data);
      end
      if (sb_q.size() != 0) begin
        wb_t e;
        e = sb_q.pop_front();
        chk("sb_num", 64'(out_write_num), 64'(e.num));
        chk("sb_data", 64'(out_write_data), 64'(e.data));
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; inbubble = 1'b1; pc = 32'h0000_4000;
    present(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, '0, '0, '0, '0);
    inbubble = 1'b1;
    set_wait(1'b0); set_rd('0);
    step(); step();
    chk("rst_rd_req", 64'(bus32.rd_req), 64'd0);
    chk("rst_wr_req", 64'(bus32.wr_req), 64'd0);
    chk("rst_wreg", 64'(out_write_reg), 64'd0);
    chk("rst_wnum", 64'(out_write_num), 64'd0);
    chk("rst_wdata", 64'(out_write_data), 64'd0);
    chk("rst_fault", 64'(out_fault), 64'd0);
    chk("rst_bubble", 64'(outbubble), 64'd1);
    rst = 1'b0;
    step();
    chk("idle_stall", 64'(outstall), 64'd0);

    // LDRB signed from 0x1003 on a 32-bit bus
    present(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 4'd1, 32'h1000, 32'd3, '0, '0);
    sb_push(4'd5, 32'hFFFF_FF80);
    #1 chk("ldrb_c0_stall", 64'(outstall), 64'd1);
    step(); inbubble = 1'b1; set_rd(32'h8012_3456);
    #1 chk("ldrb_c1_rdreq", 64'(bus32.rd_req), 64'd1);
    chk("ldrb_c1_wrreq", 64'(bus32.wr_req), 64'd0);
    chk("ldrb_c1_addr", 64'(bus32.busaddr), 64'h1000);
    step();
    chk("ldrb_c2_wreg", 64'(out_write_reg), 64'd1);
    chk("ldrb_c2_stall", 64'(outstall), 64'd0);
    chk("ldrb_c2_bubble", 64'(outbubble), 64'd0);
    step();
    chk("ldrb_c3_bubble", 64'(outbubble), 64'd1);

    // STRH at 0x2006 on both bus widths
    present(1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd2, 32'h2000, 32'd6, 32'hDEAD_1234, '0);
    step(); inbubble = 1'b1;
    chk("strh64_addr", 64'(bus64.busaddr), 64'h2000);
    chk("strh64_be", 64'(bus64.wr_be), 64'hC0);
    chk("strh64_data", bus64.wr_data, 64'h1234_1234_1234_1234);
    chk("strh64_wrreq", 64'(bus64.wr_req), 64'd1);
    chk("strh32_addr", 64'(bus32.busaddr), 64'h2004);
    chk("strh32_be", 64'(bus32.wr_be), 64'hC);
    chk("strh32_data", 64'(bus32.wr_data), 64'h1234_1234);
    step();
    chk("strh_done_wreg", 64'(out_write_reg), 64'd0);
    step();

    // LDR post-index with two wait cycles, then base writeback
    present(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 4'd3, 32'h100, 32'd8, '0, '0);
    sb_push(4'd2, 32'hCAFE_BABE);
    sb_push(4'd3, 32'h108);
    step(); inbubble = 1'b1; set_wait(1'b1); set_rd(32'hCAFE_BABE);
    #1 chk("ldrp_c1_addr", 64'(bus32.busaddr), 64'h100);
    step();
    chk("ldrp_c2_rdreq", 64'(bus32.rd_req), 64'd1);
    chk("ldrp_c2_addr", 64'(bus32.busaddr), 64'h100);
    step(); set_wait(1'b0);
    step();
    chk("ldrp_c4_wnum", 64'(out_write_num), 64'd2);
    chk("ldrp_c4_stall", 64'(outstall), 64'd1);
    chk("ldrp_c4_rdreq", 64'(bus32.rd_req), 64'd0);
    step();
    chk("ldrp_c5_wnum", 64'(out_write_num), 64'd3);
    chk("ldrp_c5_stall", 64'(outstall), 64'd0);
    step();

    // STM descending pre-index with writeback; r15 is sent as pc+12
    present(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd13, 32'h200, '0, '0, 16'h8003);
    sb_push(4'd13, 32'h1F4);
    step(); inbubble = 1'b1;
    chk("stm_b0_addr", 64'(bus32.busaddr), 64'h1FC);
    chk("stm_b0_read", 64'(st_read32), 64'd15);
    chk("stm_b0_data", 64'(bus32.wr_data), 64'h400C);
    chk("stm_b0_be", 64'(bus32.wr_be), 64'hF);
    step();
    chk("stm_b1_addr", 64'(bus32.busaddr), 64'h1F8);
    chk("stm_b1_data", 64'(bus32.wr_data), 64'hA000_0001);
    step();
    chk("stm_b2_addr", 64'(bus32.busaddr), 64'h1F4);
    chk("stm_b2_data", 64'(bus32.wr_data), 64'hA000_0000);
    step();
    chk("stm_wb_wrreq", 64'(bus32.wr_req), 64'd0);
    step();
    chk("stm_done_wreg", 64'(out_write_reg), 64'd1);
    step();

    // LDM ascending post-index with writeback
    present(1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd4, 32'h400, '0, '0, 16'h0006);
    sb_push(4'd1, 32'h1111_1111);
    sb_push(4'd2, 32'h2222_2222);
    sb_push(4'd4, 32'h408);
    step(); inbubble = 1'b1; set_rd(32'h1111_1111);
    #1 chk("ldm_b0_addr", 64'(bus32.busaddr), 64'h400);
    step(); set_rd(32'h2222_2222);
    #1 chk("ldm_b1_addr", 64'(bus32.busaddr), 64'h404);
    step(); step(); step();

    // misaligned word load at 0x102
    present(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 4'd6, 4'd1, 32'h100, 32'd2, '0, '0);
    #1 chk("flt_c0_stall", 64'(outstall), 64'd1);
    step(); inbubble = 1'b1;
    #1 chk("flt_c1_fault", 64'(out_fault), 64'd1);
    chk("flt_c1_rdreq", 64'(bus32.rd_req), 64'd0);
    chk("flt_c1_wreg", 64'(out_write_reg), 64'd0);
    chk("flt_c1_stall", 64'(outstall), 64'd0);
    step();
    chk("flt_c2_fault", 64'(out_fault), 64'd0);

    // flush while in ACCESS: op completes, next op refused once
    present(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 4'd7, 4'd1, 32'h300, '0, '0, '0);
    sb_push(4'd7, 32'h0BAD_F00D);
    step(); inbubble = 1'b1; flush = 1'b1; set_wait(1'b1); set_rd(32'h0BAD_F00D);
    step(); flush = 1'b0; set_wait(1'b0);
    step();
    chk("fl_done_wreg", 64'(out_write_reg), 64'd1);
    step();
    present(1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd8, 4'd1, 32'h300, 32'd2, '0, '0);
    sb_push(4'd8, 32'h0000_0BAD);
    #1 chk("fl_refused", 64'(outstall), 64'd0);
    step();
    chk("fl_accepted", 64'(outstall), 64'd1);
    step(); inbubble = 1'b1;
    chk("fl_half_addr", 64'(bus32.busaddr), 64'h300);
    step(); step();

    // reset in the middle of a waiting load abandons it
    present(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 4'd1, 32'h500, '0, '0, '0);
    step(); inbubble = 1'b1; set_wait(1'b1);
    #1 chk("rmid_rdreq", 64'(bus32.rd_req), 64'd1);
    rst = 1'b1;
    step();
    chk("rmid_rdreq_after", 64'(bus32.rd_req), 64'd0);
    chk("rmid_bubble", 64'(outbubble), 64'd1);
    rst = 1'b0; set_wait(1'b0);
    step();
    chk("rmid_no_write", 64'(out_write_reg), 64'd0);
    step();

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
